dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single data-memory port (mem_wea/mem_rea/mem_en/mem_addr/mem_din/mem_dout).
- Requester 0 is the core MEM stage; requester 1 is the UART/debug loader.
- The core has priority, with a starvation guard so the loader always gets a slot.
- Stalls the pipeline through mem_hold and routes 1-cycle-latency read data back to the owner of each read.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
MAX_CORE_BURST, 4, consecutive core grants allowed while the loader waits (range 1..15)

Ports:
clk  in  1  system clock
Rst  in  1  reset, asynchronous, active-low
core_req  in  1  core access request (memread | memwrite)
core_we  in  1  1 = write, 0 = read
core_be  in  4  byte-write enables
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  store data (already forwarded)
core_rdata  out  DATA_W  load data
core_rvalid  out  1  core_rdata valid
mem_hold  out  1  freeze MEM/WB registers
dbg_req  in  1  loader request
dbg_we  in  1  1 = write
dbg_be  in  4  byte enables
dbg_addr  in  ADDR_W  byte address
dbg_wdata  in  DATA_W  write data
dbg_gnt  out  1  loader request accepted this cycle
dbg_rdata  out  DATA_W  loader read data
dbg_rvalid  out  1  dbg_rdata valid
mem_wea  out  1  memory write strobe
mem_rea  out  1  memory read strobe
mem_en  out  4  byte lanes
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory read data, valid 1 cycle after mem_rea

Behaviour:
- Grant (combinational, same cycle):
  - dbg wins when dbg_req && (!core_req || wait_cnt == MAX_CORE_BURST).
  - Otherwise core wins if core_req.
  - At most one winner per cycle.
- Memory port:
  - Driven from the winner's we/be/addr/wdata.
  - mem_wea = winner & we; mem_rea = winner & !we.
  - With no winner: mem_wea = 0, mem_rea = 0, mem_en = 0, addr = 0, din = 0.
- mem_hold = core_req && !core_win. The core holds its request stable while held.
- dbg_gnt = dbg_win. The loader must hold its request until dbg_gnt; it may change the request the cycle after.
- wait_cnt register, 4 bits:
  - Increments when core wins and dbg_req = 1.
  - Clears when dbg wins or dbg_req = 0.
  - Saturates at MAX_CORE_BURST.
- Read-return register rd_owner (arb_owner_t: OWN_NONE, OWN_CORE, OWN_DBG):
  - Loaded each cycle with the winner of a read, else OWN_NONE.
  - core_rvalid = (rd_owner == OWN_CORE); dbg_rvalid = (rd_owner == OWN_DBG).
  - core_rdata = dbg_rdata = mem_dout. This is a pass-through; consumers qualify it with rvalid.
- Latency:
  - Grant in cycle N.
  - Write committed at the clk edge ending cycle N.
  - Read data plus rvalid in cycle N+1.
  - Back-to-back reads from alternating owners are legal, one per cycle.
- Reset (Rst = 0, asynchronous, any time):
  - wait_cnt = 0, rd_owner = OWN_NONE.
  - core_rvalid = dbg_rvalid = 0 immediately.
  - Combinational outputs follow inputs.
  - A read in flight at reset is dropped and no rvalid is issued. The requester re-issues after reset.
- Boundaries:
  - MAX_CORE_BURST = 1 gives strict alternation under contention.
  - Simultaneous core write and dbg read to the same address: the core write commits first when core wins. The dbg read granted later returns the new data.
  - core_req held continuously with dbg_req = 0: mem_hold stays 0 and wait_cnt stays 0.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_owner_t enum (2 bits).
  - Request struct mem_req_t {we, be[3:0], addr, wdata}.
  - Default parameter constants.
- Sub-module arb_starve_cnt holds the saturating wait counter plus grant decision. The top level holds the muxing and rd_owner.

Test Plan:
- Reset: Rst = 0 mid-read (core read 0x100 granted) -> core_rvalid stays 0 next cycle, wait_cnt = 0, all strobes follow inputs.
- Core-only: core read 0x40 (mem holds 0xDEADBEEF) -> mem_rea = 1 cycle N, core_rvalid = 1 and core_rdata = 0xDEADBEEF cycle N+1, mem_hold = 0 throughout.
- Contention, MAX = 4: core_req and dbg_req high 10 cycles -> winners C,C,C,C,D,C,C,C,C,D; mem_hold = 1 exactly on the D cycles.
- Loader write: dbg write 0x200 = 0x12345678, be = 4'b1111, core idle -> dbg_gnt = 1 same cycle, mem_wea = 1, mem_din = 0x12345678, no rvalid. A later core read of 0x200 returns 0x12345678.
- Alternating reads: dbg read 0x0 cycle N (core idle), core read 0x4 cycle N+1 -> dbg_rvalid at N+1, core_rvalid at N+2, never both high.
- Byte lanes: core sb with be = 4'b0100, addr 0x302 -> mem_en = 4'b0100, mem_wea = 1, mem_addr = 0x302.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: read-return owner
// encoding and the per-requester access record.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_BE_W           = DEF_DATA_W / 8;
  localparam int DEF_MAX_CORE_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } arb_owner_t;

  typedef struct packed {
    logic                  we;
    logic [DEF_BE_W-1:0]   be;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic              core_req;
  logic              core_we;
  logic [BE_W-1:0]   core_be;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              mem_hold;

  logic              dbg_req;
  logic              dbg_we;
  logic [BE_W-1:0]   dbg_be;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  logic              mem_wea;
  logic              mem_rea;
  logic [BE_W-1:0]   mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    output core_rdata, core_rvalid, mem_hold,
    input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_wea, mem_rea, mem_en, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output core_req, core_we, core_be, core_addr, core_wdata,
    input  core_rdata, core_rvalid, mem_hold,
    output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_wea, mem_rea, mem_en, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/dmem_arbiter_starve.sv
// Grant decision with a saturating starvation guard: the core keeps priority
// until the loader has watched MAX_CORE_BURST core grants go by.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_CORE_BURST = DEF_MAX_CORE_BURST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic core_req,
  input  logic dbg_req,
  output logic core_win,
  output logic dbg_win
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CORE_BURST);

  logic [3:0] wait_cnt;

  always_comb begin
    dbg_win  = dbg_req && (!core_req || (wait_cnt == MAX_CNT));
    core_win = core_req && !dbg_win;
  end

  // Counts only while the loader is actually waiting; any loader grant or
  // withdrawn request restarts the burst window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (dbg_win || !dbg_req) begin
      wait_cnt <= '0;
    end else if (core_win && (wait_cnt < MAX_CNT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: core priority with a
// loader starvation guard, plus 1-cycle read-data return routing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int MAX_CORE_BURST = DEF_MAX_CORE_BURST
) (
  input  logic           clk,
  input  logic           Rst,
  dmem_arbiter_if.slave  bus
);

  logic              core_win;
  logic              dbg_win;
  logic              any_win;
  mem_req_t          core_r;
  mem_req_t          dbg_r;
  mem_req_t          win_r;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  arb_owner_t        rd_owner;

  arb_starve_cnt #(
    .MAX_CORE_BURST (MAX_CORE_BURST)
  ) u_starve (
    .clk      (clk),
    .rst_n    (Rst),
    .core_req (bus.core_req),
    .dbg_req  (bus.dbg_req),
    .core_win (core_win),
    .dbg_win  (dbg_win)
  );

  assign any_win = core_win | dbg_win;

  // An idle port drives all-zero so the memory sees no stray lanes or address.
  always_comb begin
    core_r = '{we: bus.core_we, be: bus.core_be, addr: bus.core_addr, wdata: bus.core_wdata};
    dbg_r  = '{we: bus.dbg_we,  be: bus.dbg_be,  addr: bus.dbg_addr,  wdata: bus.dbg_wdata};
    win_r  = '0;
    if (dbg_win) begin
      win_r = dbg_r;
    end else if (core_win) begin
      win_r = core_r;
    end
  end

  assign win_addr  = win_r.addr;
  assign win_wdata = win_r.wdata;

  assign bus.mem_wea  = any_win & win_r.we;
  assign bus.mem_rea  = any_win & ~win_r.we;
  assign bus.mem_en   = win_r.be;
  assign bus.mem_addr = win_addr;
  assign bus.mem_din  = win_wdata;

  assign bus.mem_hold = bus.core_req & ~core_win;
  assign bus.dbg_gnt  = dbg_win;

  // Remembers who issued last cycle's read so the returning word is tagged.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rd_owner <= OWN_NONE;
    end else if (any_win && !win_r.we) begin
      rd_owner <= dbg_win ? OWN_DBG : OWN_CORE;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  assign bus.core_rvalid = (rd_owner == OWN_CORE);
  assign bus.dbg_rvalid  = (rd_owner == OWN_DBG);
  assign bus.core_rdata  = bus.mem_dout;
  assign bus.dbg_rdata   = bus.mem_dout;

endmodule
